// File: rtl/mem_pkg.sv
// Shared types for the global-memory port arbiter and its neighbours.
package mem_pkg;

    localparam int ADDR_BITS_DEFAULT = 8;
    localparam int DATA_BITS_DEFAULT = 8;

    typedef logic [ADDR_BITS_DEFAULT-1:0] addr_t;
    typedef logic [DATA_BITS_DEFAULT-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_CHANNELS = 4,
    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]        ptr,
    output logic [PTR_W-1:0]        grant,
    output logic                    any
);

    // Walk the channels starting from ptr and keep the first active one.
    always_comb begin
        int idx;
        logic [PTR_W-1:0] sel;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            sel = idx[PTR_W-1:0];
            if (!any && req[sel]) begin
                any   = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging per-channel read/write requests onto one memory port,
// with one outstanding transaction and a watchdog that aborts hung accesses.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_CHANNELS-1:0]                ch_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_read_address,
    output logic [NUM_CHANNELS-1:0]                ch_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_read_data,
    input  logic [NUM_CHANNELS-1:0]                ch_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_write_data,
    output logic [NUM_CHANNELS-1:0]                ch_write_ready,
    output logic                                   mem_read_valid,
    output logic [ADDR_BITS-1:0]                   mem_read_address,
    input  logic                                   mem_read_ready,
    input  logic [DATA_BITS-1:0]                   mem_read_data,
    output logic                                   mem_write_valid,
    output logic [ADDR_BITS-1:0]                   mem_write_address,
    output logic [DATA_BITS-1:0]                   mem_write_data,
    input  logic                                   mem_write_ready,
    output logic                                   timeout_err,
    output logic [CH_W-1:0]                        timeout_channel
);

    arb_state_t state, state_next;

    logic [CH_W-1:0]         rr_ptr, rr_ptr_next;
    logic [NUM_CHANNELS-1:0] mask, mask_next;
    logic [CNT_W-1:0]        counter, counter_next;
    logic [CH_W-1:0]         grant_q, grant_next;
    logic                    is_read, is_read_next;

    logic [NUM_CHANNELS-1:0]                read_ready_next;
    logic [NUM_CHANNELS-1:0]                write_ready_next;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_next;
    logic                                   mem_read_valid_next;
    logic [ADDR_BITS-1:0]                   mem_read_address_next;
    logic                                   mem_write_valid_next;
    logic [ADDR_BITS-1:0]                   mem_write_address_next;
    logic [DATA_BITS-1:0]                   mem_write_data_next;
    logic                                   timeout_err_next;
    logic [CH_W-1:0]                        timeout_channel_next;

    logic [NUM_CHANNELS-1:0] req;
    logic [CH_W-1:0]         pick_grant;
    logic                    pick_any;
    logic                    done;
    logic                    expired;
    logic [CH_W-1:0]         ptr_after_grant;

    // A channel that just finished is masked so its not-yet-dropped valid is skipped.
    assign req = (ch_read_valid | ch_write_valid) & ~mask;

    rr_picker #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_picker (
        .req  (req),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .any  (pick_any)
    );

    // Completion of the outstanding access: only the ready of the matching type counts.
    assign done    = is_read ? mem_read_ready : mem_write_ready;
    assign expired = (counter == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ptr_after_grant = (grant_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_q + CH_W'(1);

    // Next-state and next-register values for the IDLE/WAIT/RESPOND sequence.
    always_comb begin
        state_next             = state;
        rr_ptr_next            = rr_ptr;
        mask_next              = mask;
        counter_next           = counter;
        grant_next             = grant_q;
        is_read_next           = is_read;
        read_ready_next        = '0;
        write_ready_next       = '0;
        read_data_next         = ch_read_data;
        mem_read_valid_next    = mem_read_valid;
        mem_read_address_next  = mem_read_address;
        mem_write_valid_next   = mem_write_valid;
        mem_write_address_next = mem_write_address;
        mem_write_data_next    = mem_write_data;
        timeout_err_next       = timeout_err;
        timeout_channel_next   = timeout_channel;

        case (state)
            IDLE: begin
                // Mask always clears here: on a grant, or after one idle cycle for a lone requester.
                mask_next = '0;
                if (pick_any) begin
                    grant_next   = pick_grant;
                    is_read_next = ch_read_valid[pick_grant];
                    counter_next = '0;
                    state_next   = WAIT;
                    if (ch_read_valid[pick_grant]) begin
                        mem_read_valid_next   = 1'b1;
                        mem_read_address_next = ch_read_address[pick_grant];
                    end else begin
                        mem_write_valid_next   = 1'b1;
                        mem_write_address_next = ch_write_address[pick_grant];
                        mem_write_data_next    = ch_write_data[pick_grant];
                    end
                end
            end
            WAIT: begin
                counter_next = counter + CNT_W'(1);
                if (done || expired) begin
                    mem_read_valid_next  = 1'b0;
                    mem_write_valid_next = 1'b0;
                    // Abort also advances the pointer so a hung channel cannot hog the port.
                    rr_ptr_next          = ptr_after_grant;
                    state_next           = RESPOND;
                    if (is_read) begin
                        read_ready_next[grant_q] = 1'b1;
                        read_data_next[grant_q]  = done ? mem_read_data : '0;
                    end else begin
                        write_ready_next[grant_q] = 1'b1;
                    end
                    if (!done) begin
                        timeout_err_next     = 1'b1;
                        timeout_channel_next = grant_q;
                    end
                end
            end
            RESPOND: begin
                mask_next[grant_q] = 1'b1;
                state_next         = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr            <= '0;
            mask              <= '0;
            counter           <= '0;
            grant_q           <= '0;
            is_read           <= 1'b0;
            ch_read_ready     <= '0;
            ch_write_ready    <= '0;
            ch_read_data      <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            timeout_err       <= 1'b0;
            timeout_channel   <= '0;
        end else begin
            rr_ptr            <= rr_ptr_next;
            mask              <= mask_next;
            counter           <= counter_next;
            grant_q           <= grant_next;
            is_read           <= is_read_next;
            ch_read_ready     <= read_ready_next;
            ch_write_ready    <= write_ready_next;
            ch_read_data      <= read_data_next;
            mem_read_valid    <= mem_read_valid_next;
            mem_read_address  <= mem_read_address_next;
            mem_write_valid   <= mem_write_valid_next;
            mem_write_address <= mem_write_address_next;
            mem_write_data    <= mem_write_data_next;
            timeout_err       <= timeout_err_next;
            timeout_channel   <= timeout_channel_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small memory responder.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int TO = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NC-1:0]          ch_read_valid;
    logic [NC-1:0][AB-1:0]  ch_read_address;
    logic [NC-1:0]          ch_read_ready;
    logic [NC-1:0][DB-1:0]  ch_read_data;
    logic [NC-1:0]          ch_write_valid;
    logic [NC-1:0][AB-1:0]  ch_write_address;
    logic [NC-1:0][DB-1:0]  ch_write_data;
    logic [NC-1:0]          ch_write_ready;
    logic                   mem_read_valid;
    logic [AB-1:0]          mem_read_address;
    logic                   mem_read_ready;
    data_t                  mem_read_data;
    logic                   mem_write_valid;
    logic [AB-1:0]          mem_write_address;
    logic [DB-1:0]          mem_write_data;
    logic                   mem_write_ready;
    logic                   timeout_err;
    logic [1:0]             timeout_channel;

    mem_port_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ch_read_valid(ch_read_valid), .ch_read_address(ch_read_address),
        .ch_read_ready(ch_read_ready), .ch_read_data(ch_read_data),
        .ch_write_valid(ch_write_valid), .ch_write_address(ch_write_address),
        .ch_write_data(ch_write_data), .ch_write_ready(ch_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .timeout_err(timeout_err), .timeout_channel(timeout_channel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr;
        int a;
        int b;
    } rec_t;

    rec_t       issues[$];
    rec_t       events[$];
    int         checks = 0;
    int         failures = 0;
    int         violations = 0;
    int         resp_mode = 0;
    int         resp_latency = 1;
    int         wait_cnt = 0;
    int         rvalid_cycles = 0;
    data_t      resp_data = 8'h00;
    bit [NC-1:0] drop_read = '0;
    bit [NC-1:0] drop_write = '0;
    bit         prev_rv = 1'b0;
    bit         prev_wv = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIssue(input string tag, input int k, input int wr, input int a, input int b);
        if (k < issues.size()) begin
            checkOutput({tag, "_type"}, issues[k].wr, wr);
            checkOutput({tag, "_addr"}, issues[k].a, a);
            checkOutput({tag, "_data"}, issues[k].b, b);
        end else begin
            checkOutput({tag, "_missing"}, issues.size(), k + 1);
        end
    endtask

    task automatic checkEvent(input string tag, input int k, input int wr, input int ch, input int val);
        if (k < events.size()) begin
            checkOutput({tag, "_type"}, events[k].wr, wr);
            checkOutput({tag, "_chan"}, events[k].a, ch);
            checkOutput({tag, "_data"}, events[k].b, val);
        end else begin
            checkOutput({tag, "_missing"}, events.size(), k + 1);
        end
    endtask

    task automatic applyStimulus(input int ch, input bit wr, input int addr, input int data);
        if (wr) begin
            ch_write_valid[ch]   = 1'b1;
            ch_write_address[ch] = AB'(addr);
            ch_write_data[ch]    = DB'(data);
        end else begin
            ch_read_valid[ch]   = 1'b1;
            ch_read_address[ch] = AB'(addr);
        end
    endtask

    // One cycle: observe at the falling edge, then update channel valids and memory readies.
    task automatic tick();
        rec_t r;
        @(negedge clk);
        if (mem_read_valid && mem_write_valid) violations++;
        if ($countones({ch_read_ready, ch_write_ready}) > 1) violations++;
        if (mem_read_valid && !prev_rv) begin
            r.wr = 0; r.a = int'(mem_read_address); r.b = 0;
            issues.push_back(r);
            rvalid_cycles = 0;
        end
        if (mem_read_valid) rvalid_cycles++;
        if (mem_write_valid && !prev_wv) begin
            r.wr = 1; r.a = int'(mem_write_address); r.b = int'(mem_write_data);
            issues.push_back(r);
        end
        prev_rv = mem_read_valid;
        prev_wv = mem_write_valid;
        ch_read_valid  = ch_read_valid & ~drop_read;
        ch_write_valid = ch_write_valid & ~drop_write;
        drop_read  = '0;
        drop_write = '0;
        for (int i = 0; i < NC; i++) begin
            if (ch_read_ready[i]) begin
                r.wr = 0; r.a = i; r.b = int'(ch_read_data[i]);
                events.push_back(r);
                drop_read[i] = 1'b1;
            end
            if (ch_write_ready[i]) begin
                r.wr = 1; r.a = i; r.b = 0;
                events.push_back(r);
                drop_write[i] = 1'b1;
            end
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = 8'hEE;
        if (mem_read_valid || mem_write_valid) wait_cnt++;
        else wait_cnt = 0;
        if (resp_mode == 0 && wait_cnt == resp_latency) begin
            if (mem_read_valid) begin
                mem_read_ready = 1'b1;
                mem_read_data  = resp_data;
            end else if (mem_write_valid) begin
                mem_write_ready = 1'b1;
            end
        end
        if (resp_mode == 2) begin
            if (mem_read_valid)  mem_write_ready = 1'b1;
            if (mem_write_valid) mem_read_ready  = 1'b1;
        end
    endtask

    task automatic runUntilDone(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (ch_read_valid == '0) && (ch_write_valid == '0) && !mem_read_valid &&
                   !mem_write_valid && (ch_read_ready == '0) && (ch_write_ready == '0) &&
                   (drop_read == '0) && (drop_write == '0);
        end
        checkOutput({tag, "_drained"}, 32'(done), 1);
        repeat (3) tick();
    endtask

    task automatic clearInputs();
        ch_read_valid    = '0;
        ch_write_valid   = '0;
        ch_read_address  = '0;
        ch_write_address = '0;
        ch_write_data    = '0;
        mem_read_ready   = 1'b0;
        mem_write_ready  = 1'b0;
        mem_read_data    = 8'h00;
        drop_read        = '0;
        drop_write       = '0;
        wait_cnt         = 0;
        prev_rv          = 1'b0;
        prev_wv          = 1'b0;
        resp_mode        = 0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: observed=expired expected=finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        reset_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_rvalid", mem_read_valid, 0);
        checkOutput("rst_mem_wvalid", mem_write_valid, 0);
        checkOutput("rst_ch_rready", ch_read_ready, 0);
        checkOutput("rst_ch_wready", ch_write_ready, 0);
        checkOutput("rst_ch_rdata", ch_read_data, 0);
        checkOutput("rst_mem_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
        checkOutput("rst_timeout", {timeout_err, timeout_channel}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] single read on ch1");
        issues.delete(); events.delete();
        resp_latency = 2; resp_data = 8'hA5;
        applyStimulus(1, 0, 'h12, 0);
        runUntilDone("t1", 40);
        checkOutput("t1_issue_count", issues.size(), 1);
        checkIssue("t1_issue", 0, 0, 'h12, 0);
        checkOutput("t1_event_count", events.size(), 1);
        checkEvent("t1_ready", 0, 0, 1, 'hA5);
        checkOutput("t1_rdata1", ch_read_data[1], 'hA5);
        checkOutput("t1_terr", timeout_err, 0);

        $display("[TB] round robin writes on all channels");
        doReset();
        issues.delete(); events.delete();
        resp_latency = 1;
        for (int i = 0; i < NC; i++) applyStimulus(i, 1, 'h40 + i, 'h10 + i);
        runUntilDone("t2", 100);
        checkOutput("t2_issue_count", issues.size(), 4);
        checkOutput("t2_event_count", events.size(), 4);
        for (int k = 0; k < NC; k++) begin
            checkIssue($sformatf("t2_issue%0d", k), k, 1, 'h40 + k, 'h10 + k);
            checkEvent($sformatf("t2_ack%0d", k), k, 1, k, 0);
        end

        $display("[TB] no double grant on ch2");
        issues.delete(); events.delete();
        resp_data = 8'h3C;
        applyStimulus(2, 0, 'h77, 0);
        runUntilDone("t3", 40);
        repeat (10) tick();
        checkOutput("t3_issue_count", issues.size(), 1);
        checkOutput("t3_event_count", events.size(), 1);
        checkEvent("t3_ready", 0, 0, 2, 'h3C);

        $display("[TB] wrap from ch3 to ch0");
        issues.delete(); events.delete();
        resp_data = 8'h5A;
        applyStimulus(0, 0, 'h05, 0);
        applyStimulus(3, 1, 'h33, 'hC3);
        runUntilDone("t4", 60);
        checkOutput("t4_issue_count", issues.size(), 2);
        checkIssue("t4_first", 0, 1, 'h33, 'hC3);
        checkIssue("t4_second", 1, 0, 'h05, 0);
        checkEvent("t4_ev0", 0, 1, 3, 0);
        checkEvent("t4_ev1", 1, 0, 0, 'h5A);

        $display("[TB] read before write on the same channel");
        issues.delete(); events.delete();
        resp_data = 8'h99;
        applyStimulus(1, 0, 'h11, 0);
        applyStimulus(1, 1, 'h19, 'h91);
        runUntilDone("t4b", 60);
        checkOutput("t4b_issue_count", issues.size(), 2);
        checkIssue("t4b_first", 0, 0, 'h11, 0);
        checkIssue("t4b_second", 1, 1, 'h19, 'h91);
        checkEvent("t4b_ev0", 0, 0, 1, 'h99);
        checkEvent("t4b_ev1", 1, 1, 1, 0);
        checkOutput("t4b_rdata0", ch_read_data[0], 'h5A);
        checkOutput("t4b_rdata1", ch_read_data[1], 'h99);

        $display("[TB] watchdog abort on ch1 with wrong-type ready");
        issues.delete(); events.delete();
        resp_mode = 2;
        applyStimulus(1, 0, 'h21, 0);
        runUntilDone("t5", 60);
        checkOutput("t5_issue_count", issues.size(), 1);
        checkIssue("t5_issue", 0, 0, 'h21, 0);
        checkOutput("t5_wait_cycles", rvalid_cycles, TO);
        checkOutput("t5_event_count", events.size(), 1);
        checkEvent("t5_ready", 0, 0, 1, 0);
        checkOutput("t5_rdata1", ch_read_data[1], 0);
        checkOutput("t5_rdata0", ch_read_data[0], 'h5A);
        checkOutput("t5_terr", timeout_err, 1);
        checkOutput("t5_tchan", timeout_channel, 1);

        $display("[TB] reset during an outstanding ch0 read");
        issues.delete(); events.delete();
        resp_mode = 1;
        applyStimulus(0, 0, 'h0A, 0);
        for (int n = 0; n < 10 && !mem_read_valid; n++) tick();
        checkOutput("t6_issued", mem_read_valid, 1);
        tick();
        tick();
        reset_n = 1'b0;
        clearInputs();
        #1;
        checkOutput("t6_rst_rvalid", mem_read_valid, 0);
        checkOutput("t6_rst_terr", timeout_err, 0);
        checkOutput("t6_rst_tchan", timeout_channel, 0);
        checkOutput("t6_rst_rdata", ch_read_data, 0);
        checkOutput("t6_rst_readies", {ch_read_ready, ch_write_ready}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issues.delete(); events.delete();
        resp_latency = 1;
        applyStimulus(3, 1, 'h3E, 'hE3);
        runUntilDone("t6", 40);
        checkOutput("t6_issue_count", issues.size(), 1);
        checkIssue("t6_issue", 0, 1, 'h3E, 'hE3);
        checkOutput("t6_event_count", events.size(), 1);
        checkEvent("t6_ack", 0, 1, 3, 0);
        checkOutput("t6_terr", timeout_err, 0);

        checkOutput("protocol_violations", violations, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
